pipe_reg_chain: RTL and testbench

// - Parametrised successor of the single always_ff capture register: a STAGES-deep chain of

---
 rtl/pipe_reg_chain.sv | 115 +++++++++++
 tb/tb_pipe_reg_chain.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: STAGES-deep chain of WIDTH-bit register slices with
// per-stage valid bits, valid/ready backpressure and bubble collapse.
// The number of occupied stages is exported as a registered count.
// Optional feature: define PIPE_REG_CHAIN_FLUSH_EN to add a 1-bit flush
// input that empties the chain (valid bits only) at the next clock edge.
module pipe_reg_chain #(
    parameter  int WIDTH  = 8,
    parameter  int STAGES = 3,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
`ifdef PIPE_REG_CHAIN_FLUSH_EN
    input  logic             flush,
`endif
    output logic [CW-1:0]    count
);

    if (STAGES < 1) begin : g_bad_stages
        $error("pipe_reg_chain: STAGES must be >= 1");
    end

    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [CW-1:0]     r_count;

    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_prev_vld;
    logic [WIDTH-1:0]  w_prev_data [STAGES];
    logic [STAGES-1:0] w_vld_nxt;
    logic              w_flush;

`ifdef PIPE_REG_CHAIN_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Number of set bits in a stage-valid vector.
    function automatic logic [CW-1:0] popcount(input logic [STAGES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < STAGES; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Each stage is fed by its predecessor; stage 0 is fed by the input port.
    for (genvar g = 0; g < STAGES; g++) begin : g_prev
        if (g == 0) begin : g_head
            assign w_prev_vld[g]  = in_valid;
            assign w_prev_data[g] = in_data;
        end else begin : g_link
            assign w_prev_vld[g]  = r_vld[g-1];
            assign w_prev_data[g] = r_data[g-1];
        end
    end

    // Ready ripples back from the output: a stage can load when it is empty
    // or when the stage after it is loading too, which collapses bubbles.
    always_comb begin
        w_rdy = '0;
        w_rdy[STAGES-1] = !r_vld[STAGES-1] || out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            w_rdy[i] = !r_vld[i] || w_rdy[i+1];
        end
    end

    // Next valid vector: loading stages take the predecessor's valid, others hold.
    always_comb begin
        w_vld_nxt = r_vld;
        for (int i = 0; i < STAGES; i++) begin
            if (w_rdy[i]) begin
                w_vld_nxt[i] = w_prev_vld[i];
            end
        end
    end

    // Stage registers and occupancy count; data only moves with a valid beat
    // so an empty stage keeps its last payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_count <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else if (w_flush) begin
            r_vld   <= '0;
            r_count <= '0;
        end else begin
            r_vld   <= w_vld_nxt;
            r_count <= popcount(w_vld_nxt);
            for (int i = 0; i < STAGES; i++) begin
                if (w_rdy[i] && w_prev_vld[i]) begin
                    r_data[i] <= w_prev_data[i];
                end
            end
        end
    end

    // Flush blocks both handshakes for its cycle so no beat crosses either end.
    assign in_ready  = w_rdy[0] && !w_flush;
    assign out_valid = r_vld[STAGES-1] && !w_flush;
    assign out_data  = r_data[STAGES-1];
    assign count     = r_count;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Testbench for pipe_reg_chain (WIDTH=8, STAGES=3): directed vectors with a
// scoreboard queue filled on each input accept and drained by an output monitor.
module tb_pipe_reg_chain;

    localparam int WIDTH  = 8;
    localparam int STAGES = 3;
    localparam int CW     = $clog2(STAGES + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
`ifdef PIPE_REG_CHAIN_FLUSH_EN
    logic             flush;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cnt_max = 0;
    int acc_cyc = 0;
    int acc_q [$];
    int out_cyc_q [$];
    logic [WIDTH-1:0] exp_q [$];

    pipe_reg_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef PIPE_REG_CHAIN_FLUSH_EN
        .flush     (flush),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output side of the scoreboard: every output transfer pops one expected beat.
    task automatic monitor();
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got 0x%0h, expected no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e));
                end
                out_cyc_q.push_back(cyc);
            end
            if (int'(count) > cnt_max) cnt_max = int'(count);
        end
    endtask

    // Present one beat and hold it until accepted (bounded); leaves in_valid high.
    task automatic send(input logic [WIDTH-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back(d);
            acc_cyc = cyc;
            acc_q.push_back(cyc);
        end
        tick();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef PIPE_REG_CHAIN_FLUSH_EN
        flush     = 1'b0;
`endif
        fork
            monitor();
        join_none

        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        tick();

        // Streaming
        out_ready = 1'b1;
        cnt_max = 0;
        acc_q.delete();
        out_cyc_q.delete();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        in_valid = 1'b0;
        wait_drain("stream_drain");
        chk("stream_accepts_b2b", 32'(acc_q[3] - acc_q[0]), 32'd3);
        chk("stream_latency",     32'(out_cyc_q[0] - acc_q[0]), 32'd3);
        chk("stream_out_b2b",     32'(out_cyc_q[3] - out_cyc_q[0]), 32'd3);
        chk("stream_count_peak",  32'(cnt_max), 32'd3);
        tick();
        chk("stream_count_empty", 32'(count), 32'd0);

        // Stall fill
        out_ready = 1'b0;
        send(8'hA0);
        send(8'hA1);
        send(8'hA2);
        in_data = 8'hA3;
        @(negedge clk);
        chk("fill_in_ready",  32'(in_ready),  32'd0);
        chk("fill_count",     32'(count),     32'd3);
        chk("fill_out_valid", 32'(out_valid), 32'd1);
        chk("fill_out_data",  32'(out_data),  32'hA0);
        tick();
        @(negedge clk);
        chk("fill_stable_data", 32'(out_data), 32'hA0);
        chk("fill_stable_rdy",  32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back(8'hA3);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("release_count", 32'(count), 32'd3);
        wait_drain("fill_drain");

        // Bubble collapse
        tick();
        out_ready = 1'b0;
        send(8'h01);
        in_valid = 1'b0;
        tick();
        tick();
        send(8'h02);
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("bubble_count",     32'(count),     32'd2);
        chk("bubble_out_valid", 32'(out_valid), 32'd1);
        chk("bubble_out_data",  32'(out_data),  32'h01);
        chk("bubble_in_ready",  32'(in_ready),  32'd1);
        tick();
        out_ready = 1'b1;
        wait_drain("bubble_drain");

        // Mid-stream reset
        tick();
        out_ready = 1'b0;
        send(8'h55);
        send(8'h66);
        in_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("midrst_pre_count", 32'(count), 32'd2);
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_count",     32'(count),     32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data",  32'(out_data),  32'h00);
        tick();
        out_ready = 1'b1;
        begin
            int n_out;
            n_out = out_cyc_q.size();
            for (int k = 0; k < 6; k++) tick();
            chk("midrst_no_emerge", 32'(out_cyc_q.size()), 32'(n_out));
        end

`ifdef PIPE_REG_CHAIN_FLUSH_EN
        // Flush
        out_ready = 1'b0;
        send(8'hC0);
        send(8'hC1);
        send(8'hC2);
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 8'hEE;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready",  32'(in_ready),  32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_count", 32'(count), 32'd0);
        tick();
        out_ready = 1'b1;
        out_cyc_q.delete();
        send(8'hD0);
        in_valid = 1'b0;
        wait_drain("flush_drain");
        if (out_cyc_q.size() == 1)
            chk("flush_latency", 32'(out_cyc_q[0] - acc_cyc), 32'd3);
        else
            chk("flush_out_beats", 32'(out_cyc_q.size()), 32'd1);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
